// File: rtl/muldiv_if.sv
// Handshake and result bus between the control unit and the MULT/DIV sequencer.
interface muldiv_if #(parameter int WIDTH = 32);
    logic             start;
    logic             op;
    logic             cancel;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             busy;
    logic             done;
    logic             div_zero;
    logic             hi_lo_we;
    logic [WIDTH-1:0] hi_out;
    logic [WIDTH-1:0] lo_out;

    modport master (
        output start, op, cancel, a_in, b_in,
        input  busy, done, div_zero, hi_lo_we, hi_out, lo_out
    );

    modport slave (
        input  start, op, cancel, a_in, b_in,
        output busy, done, div_zero, hi_lo_we, hi_out, lo_out
    );
endinterface

// File: rtl/muldiv_seq.sv
// Multi-cycle signed MULT/DIV sequencer driving the HI/LO registers.
// Magnitudes are processed unsigned; signs are reapplied in FIX.
module muldiv_seq #(
    parameter int WIDTH = 32
) (
    input logic     clock,
    input logic     reset,
    muldiv_if.slave bus
);
    localparam int CW = $clog2(WIDTH) + 1;

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] SETUP = 3'd1;
    localparam logic [2:0] RUN   = 3'd2;
    localparam logic [2:0] FIX   = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;

    logic [2:0]         state;
    logic               opReg;
    logic               signA;
    logic               signB;
    logic               divZero;
    logic [WIDTH-1:0]   aReg;
    logic [WIDTH-1:0]   bReg;
    logic [WIDTH-1:0]   hiReg;
    logic [WIDTH-1:0]   loReg;
    logic [2*WIDTH-1:0] acc;
    logic [CW-1:0]      count;

    logic [WIDTH-1:0]   absA;
    logic [WIDTH-1:0]   absB;
    logic [WIDTH:0]     mulSum;
    logic [WIDTH:0]     divShift;
    logic [WIDTH:0]     divDiff;
    logic               divGe;
    logic [2*WIDTH-1:0] accNext;
    logic [2*WIDTH-1:0] prodFix;
    logic [WIDTH-1:0]   quoFix;
    logic [WIDTH-1:0]   remFix;

    // After SETUP, aReg/bReg hold |a| and |b|.
    always_comb begin
        absA     = aReg[WIDTH-1] ? -aReg : aReg;
        absB     = bReg[WIDTH-1] ? -bReg : bReg;
        mulSum   = {1'b0, acc[2*WIDTH-1:WIDTH]}
                 + {1'b0, (acc[0] ? aReg : {WIDTH{1'b0}})};
        divShift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        divDiff  = divShift - {1'b0, bReg};
        // Borrow out of the (WIDTH+1)-bit subtract means "does not fit".
        divGe    = !divDiff[WIDTH];
        if (opReg) begin
            accNext = {(divGe ? divDiff[WIDTH-1:0] : divShift[WIDTH-1:0]),
                       acc[WIDTH-2:0], divGe};
        end else begin
            accNext = {mulSum, acc[WIDTH-1:1]};
        end
        prodFix = (signA ^ signB) ? -acc : acc;
        quoFix  = (signA ^ signB) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        remFix  = signA ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            opReg   <= 1'b0;
            signA   <= 1'b0;
            signB   <= 1'b0;
            divZero <= 1'b0;
            aReg    <= '0;
            bReg    <= '0;
            hiReg   <= '0;
            loReg   <= '0;
            acc     <= '0;
            count   <= '0;
        end else if (bus.cancel && state != IDLE) begin
            state   <= IDLE;
            divZero <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        opReg <= bus.op;
                        aReg  <= bus.a_in;
                        bReg  <= bus.b_in;
                        state <= SETUP;
                    end
                end
                SETUP: begin
                    signA <= aReg[WIDTH-1];
                    signB <= bReg[WIDTH-1];
                    aReg  <= absA;
                    bReg  <= absB;
                    count <= '0;
                    if (opReg && bReg == '0) begin
                        divZero <= 1'b1;
                        state   <= DONE;
                    end else begin
                        acc   <= {{WIDTH{1'b0}}, (opReg ? absA : absB)};
                        state <= RUN;
                    end
                end
                RUN: begin
                    acc   <= accNext;
                    count <= count + 1'b1;
                    if (count == CW'(WIDTH - 1)) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    if (opReg) begin
                        hiReg <= remFix;
                        loReg <= quoFix;
                    end else begin
                        hiReg <= prodFix[2*WIDTH-1:WIDTH];
                        loReg <= prodFix[WIDTH-1:0];
                    end
                    state <= DONE;
                end
                DONE: begin
                    divZero <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy     = (state != IDLE);
    assign bus.done     = (state == DONE);
    assign bus.div_zero = (state == DONE) && divZero;
    assign bus.hi_lo_we = (state == DONE) && !divZero;
    assign bus.hi_out   = hiReg;
    assign bus.lo_out   = loReg;
endmodule
